// File: rtl/d_uncache_bridge_pkg.sv
// Shared definitions for the uncached data-port AXI bridge: state encodings,
// AXI field constants and the legacy word-bus types.
package d_uncache_bridge_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [ADDR_W_DEF-1:0] WordAddrBus;
    typedef logic [DATA_W_DEF-1:0] WordDataBus;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRdAr  = 3'd1;
    localparam logic [2:0] StRdR   = 3'd2;
    localparam logic [2:0] StWrAwW = 3'd3;
    localparam logic [2:0] StWrB   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_1     = 3'b000;
    localparam logic [2:0] SIZE_2     = 3'b001;
    localparam logic [2:0] SIZE_4     = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage

// File: rtl/d_uncache_bridge_if.sv
// Single-beat AXI4 read/write channel bundle between the uncached bridge
// (master) and the system interconnect (slave).
interface d_uncache_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [3:0]        awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/d_uncache_size_enc.sv
// Maps a store byte-strobe pattern to the AXI transfer size and the mask
// applied to the two low address bits.
module d_uncache_size_enc
    import d_uncache_bridge_pkg::*;
(
    input  logic [3:0] rwen_i,
    output logic [2:0] size_o,
    output logic [1:0] addr_lo_mask_o
);

    always_comb begin
        size_o         = SIZE_4;
        addr_lo_mask_o = 2'b00;
        unique case (rwen_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                size_o         = SIZE_1;
                addr_lo_mask_o = 2'b11;
            end
            4'b0011, 4'b1100: begin
                size_o         = SIZE_2;
                addr_lo_mask_o = 2'b11;
            end
            // Irregular or empty strobes go out as a full aligned word.
            default: begin
                size_o         = SIZE_4;
                addr_lo_mask_o = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/d_uncache_bridge.sv
// Uncached D-port responder: turns one cpu_mem_uncache request at a time into a
// single-beat AXI4 read or write and returns a registered completion pulse.
module d_uncache_bridge
    import d_uncache_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter logic [3:0]  AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uc_en,
    input  logic              uc_rw,
    input  logic [3:0]        uc_rwen,
    input  logic [ADDR_W-1:0] uc_addr,
    input  logic [DATA_W-1:0] uc_wr_data,
    output logic [DATA_W-1:0] uc_rd_data,
    output logic              uc_data_ok,
    output logic              uc_err,
    output logic              busy,
    d_uncache_bridge_if.master axi
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        rwen_q, rwen_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;

    logic [2:0] wr_size;
    logic [1:0] addr_lo_mask;
    logic       unused_rlast;

    assign unused_rlast = axi.rlast;

    d_uncache_size_enc u_size_enc (
        .rwen_i        (rwen_q),
        .size_o        (wr_size),
        .addr_lo_mask_o(addr_lo_mask)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rwen_d    = rwen_q;
        wr_data_d = wr_data_q;
        rd_data_d = rd_data_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        case (state_q)
            StIdle: begin
                if (uc_en) begin
                    addr_d    = uc_addr;
                    rwen_d    = uc_rwen;
                    wr_data_d = uc_wr_data;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = uc_rw ? StWrAwW : StRdAr;
                end
            end
            StRdAr: begin
                if (axi.arready) state_d = StRdR;
            end
            StRdR: begin
                if (axi.rvalid) begin
                    rd_data_d = axi.rdata;
                    err_d     = (axi.rresp != RESP_OKAY);
                    state_d   = StDone;
                end
            end
            StWrAwW: begin
                if (axi.awready && !aw_done_q) aw_done_d = 1'b1;
                if (axi.wready && !w_done_q)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)     state_d   = StWrB;
            end
            StWrB: begin
                if (axi.bvalid) begin
                    err_d   = (axi.bresp != RESP_OKAY);
                    state_d = StDone;
                end
            end
            // uc_en is deliberately ignored here so a held request is not reissued.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rwen_q    <= '0;
            wr_data_q <= '0;
            rd_data_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rwen_q    <= rwen_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Every uc_* output decodes registered state only; no AXI input reaches them.
    assign uc_data_ok = (state_q == StDone);
    assign uc_err     = (state_q == StDone) && err_q;
    assign uc_rd_data = rd_data_q;
    assign busy       = (state_q != StIdle);

    assign axi.araddr  = addr_q;
    assign axi.arvalid = (state_q == StRdAr);
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = LEN_SINGLE;
    assign axi.arsize  = SIZE_4;
    assign axi.arburst = BURST_INCR;
    assign axi.rready  = (state_q == StRdR);

    assign axi.awaddr  = {addr_q[ADDR_W-1:2], addr_q[1:0] & addr_lo_mask};
    assign axi.awvalid = (state_q == StWrAwW) && !aw_done_q;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = LEN_SINGLE;
    assign axi.awsize  = wr_size;
    assign axi.awburst = BURST_INCR;

    assign axi.wdata  = wr_data_q;
    assign axi.wstrb  = rwen_q;
    assign axi.wlast  = 1'b1;
    assign axi.wvalid = (state_q == StWrAwW) && !w_done_q;
    assign axi.bready = (state_q == StWrB);

endmodule

// File: tb/tb_d_uncache_bridge.sv
// Directed bench for d_uncache_bridge: drives the uncached request port, plays
// the AXI interconnect by hand and scoreboards each completion.
module tb_d_uncache_bridge;

    typedef struct {
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        uc_en;
    logic        uc_rw;
    logic [3:0]  uc_rwen;
    logic [31:0] uc_addr;
    logic [31:0] uc_wr_data;
    logic [31:0] uc_rd_data;
    logic        uc_data_ok;
    logic        uc_err;
    logic        busy;

    d_uncache_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    d_uncache_bridge #(.ADDR_W(32), .DATA_W(32), .AXI_ID(4'd1)) dut (
        .clk       (clk),
        .reset     (reset),
        .uc_en     (uc_en),
        .uc_rw     (uc_rw),
        .uc_rwen   (uc_rwen),
        .uc_addr   (uc_addr),
        .uc_wr_data(uc_wr_data),
        .uc_rd_data(uc_rd_data),
        .uc_data_ok(uc_data_ok),
        .uc_err    (uc_err),
        .busy      (busy),
        .axi       (axi)
    );

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   ar_hs  = 0;
    int   ok_cnt = 0;
    int   issued = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi.arvalid === 1'b1 && axi.arready === 1'b1) ar_hs <= ar_hs + 1;
        if (uc_data_ok === 1'b1) ok_cnt <= ok_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max);
        int   n = 0;
        exp_t e;
        while (uc_data_ok !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk("data_ok_pulse", uc_data_ok, 1);
        if (uc_data_ok === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.chk_data) chk("uc_rd_data", uc_rd_data, e.data);
            chk("uc_err", uc_err, e.err);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int ar_delay, input bit hold_en);
        uc_en = 1'b1; uc_rw = 1'b0; uc_addr = addr; uc_rwen = 4'hf;
        axi.arready = 1'b0;
        sb.push_back('{data, (resp != 2'b00), 1'b1});
        issued++;
        tick();
        chk("arvalid_start", axi.arvalid, 1);
        chk("araddr", axi.araddr, addr);
        chk("arsize", axi.arsize, 3'b010);
        chk("arlen", axi.arlen, 8'd0);
        chk("arburst", axi.arburst, 2'b01);
        chk("arid", axi.arid, 4'd1);
        chk("busy_rd", busy, 1);
        repeat (ar_delay) begin
            tick();
            chk("arvalid_hold", axi.arvalid, 1);
            chk("araddr_hold", axi.araddr, addr);
        end
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        chk("arvalid_drop", axi.arvalid, 0);
        chk("rready", axi.rready, 1);
        chk("no_early_ok", uc_data_ok, 0);
        axi.rvalid = 1'b1; axi.rdata = data; axi.rresp = resp; axi.rlast = 1'b1;
        tick();
        axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        wait_done(4);
        if (!hold_en) uc_en = 1'b0;
        tick();
        chk("ok_one_cycle", uc_data_ok, 0);
        chk("err_one_cycle", uc_err, 0);
        chk("busy_idle", busy, 0);
        chk("arvalid_idle", axi.arvalid, 0);
        chk("rd_data_hold", uc_rd_data, data);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] rwen,
                            input logic [31:0] data, input logic [2:0] exp_size,
                            input logic [31:0] exp_addr, input logic [1:0] resp,
                            input int awd, input int wd);
        bit aw_t = 1'b0;
        bit w_t  = 1'b0;
        int c    = 0;
        uc_en = 1'b1; uc_rw = 1'b1; uc_addr = addr; uc_rwen = rwen; uc_wr_data = data;
        axi.awready = 1'b0; axi.wready = 1'b0;
        sb.push_back('{32'h0, (resp != 2'b00), 1'b0});
        issued++;
        tick();
        chk("awaddr", axi.awaddr, exp_addr);
        chk("awsize", axi.awsize, exp_size);
        chk("wstrb", axi.wstrb, rwen);
        chk("wdata", axi.wdata, data);
        chk("wlast", axi.wlast, 1);
        chk("awlen", axi.awlen, 8'd0);
        chk("awburst", axi.awburst, 2'b01);
        chk("awid", axi.awid, 4'd1);
        chk("arvalid_on_wr", axi.arvalid, 0);
        while (!(aw_t && w_t) && c < 20) begin
            chk("awvalid_state", axi.awvalid, !aw_t);
            chk("wvalid_state", axi.wvalid, !w_t);
            if (!aw_t) chk("awaddr_stable", axi.awaddr, exp_addr);
            axi.awready = (c >= awd) && !aw_t;
            axi.wready  = (c >= wd) && !w_t;
            if (axi.awready) aw_t = 1'b1;
            if (axi.wready)  w_t  = 1'b1;
            tick();
            c++;
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        chk("awvalid_done", axi.awvalid, 0);
        chk("wvalid_done", axi.wvalid, 0);
        chk("bready", axi.bready, 1);
        axi.bvalid = 1'b1; axi.bresp = resp;
        tick();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        chk("bready_drop", axi.bready, 0);
        wait_done(4);
        uc_en = 1'b0;
        tick();
        chk("ok_one_cycle_wr", uc_data_ok, 0);
        chk("busy_idle_wr", busy, 0);
    endtask

    initial begin
        int base;
        reset = 1'b1; uc_en = 1'b0; uc_rw = 1'b0; uc_rwen = 4'h0;
        uc_addr = '0; uc_wr_data = '0;
        axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        axi.rvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bresp = 2'b00; axi.bvalid = 1'b0;
        repeat (2) tick();
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_rready", axi.rready, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_data_ok", uc_data_ok, 0);
        chk("rst_err", uc_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", uc_rd_data, 32'h0);
        reset = 1'b0;
        tick();

        do_read(32'h1FAF_0000, 32'hDEAD_BEEF, 2'b00, 0, 1'b0);
        // W accepted first, AW only after three more cycles.
        do_write(32'h1FAF_F002, 4'b0100, 32'h00AB_0000, 3'd0, 32'h1FAF_F002, 2'b00, 3, 0);
        do_write(32'h1000_0002, 4'b1100, 32'hCAFE_0000, 3'd1, 32'h1000_0002, 2'b00, 0, 0);
        do_write(32'h2000_0003, 4'b1111, 32'h1234_5678, 3'd2, 32'h2000_0000, 2'b00, 0, 0);
        do_write(32'h3000_0001, 4'b0010, 32'h0000_AB00, 3'd0, 32'h3000_0001, 2'b00, 0, 2);
        do_write(32'h4000_0007, 4'b0000, 32'h5555_AAAA, 3'd2, 32'h4000_0004, 2'b00, 1, 1);
        do_write(32'h4100_0006, 4'b0110, 32'h00FF_FF00, 3'd2, 32'h4100_0004, 2'b00, 2, 2);
        do_read(32'h5000_0000, 32'h0123_4567, 2'b10, 2, 1'b0);
        do_write(32'h6000_0000, 4'b0001, 32'h0000_00FF, 3'd0, 32'h6000_0000, 2'b00, 0, 0);
        do_write(32'h6000_0010, 4'b0011, 32'h0000_BEEF, 3'd1, 32'h6000_0010, 2'b11, 1, 0);

        base = ar_hs;
        do_read(32'h7000_0000, 32'hAAAA_5555, 2'b00, 0, 1'b1);
        uc_en = 1'b0;
        tick();
        chk("no_double_issue_arvalid", axi.arvalid, 0);
        chk("no_double_issue_busy", busy, 0);
        chk("single_ar_hs", ar_hs - base, 1);
        do_read(32'h8000_0000, 32'h1111_2222, 2'b00, 0, 1'b1);
        do_read(32'h8000_0004, 32'h3333_4444, 2'b00, 1, 1'b0);
        chk("b2b_ar_hs", ar_hs - base, 3);

        // Reset while waiting on R: must abandon without a completion pulse.
        uc_en = 1'b1; uc_rw = 1'b0; uc_addr = 32'h9000_0000; axi.arready = 1'b1;
        tick();
        tick();
        axi.arready = 1'b0; uc_en = 1'b0;
        chk("midop_rready", axi.rready, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midop_arvalid", axi.arvalid, 0);
        chk("midop_rready_clr", axi.rready, 0);
        chk("midop_awvalid", axi.awvalid, 0);
        chk("midop_wvalid", axi.wvalid, 0);
        chk("midop_bready", axi.bready, 0);
        chk("midop_busy", busy, 0);
        chk("midop_data_ok", uc_data_ok, 0);
        chk("midop_rd_data", uc_rd_data, 32'h0);
        tick();
        chk("midop_no_ok_later", uc_data_ok, 0);
        chk("midop_idle", busy, 0);

        do_read(32'hA000_0000, 32'h600D_F00D, 2'b00, 0, 1'b0);

        tick();
        chk("ok_pulse_count", ok_cnt, issued);
        chk("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
